// File: rtl/ehgu_stride_checker.sv
// ehgu_stride_checker
// Watches a sample stream for a constant increment of STRIDE (modulo 2^WIDTH).
// The checker walks IDLE -> ACQUIRE -> LOCKED. It locks after LOCK_CNT
// consecutive matches and drops lock after LOSS_CNT consecutive misses.
// Misses seen while locked are pulsed on mismatch and counted in err_cnt.
// Optional feature: define EHGU_STRIDE_CHECKER_STICKY_EN to build a latched
// error flag on err_sticky. Without it, err_sticky is a constant 0.
module ehgu_stride_checker #(
   parameter int WIDTH    = 8,
   parameter int STRIDE   = 3,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 2,
   parameter int ERR_CW   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              clr,
   input  logic [WIDTH-1:0]  data_in,
   output logic [WIDTH-1:0]  expected,
   output logic              locked,
   output logic              mismatch,
   output logic [ERR_CW-1:0] err_cnt,
   output logic              err_sticky
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(LOSS_CNT + 1);

   localparam logic [WIDTH-1:0]   STEP       = WIDTH'(STRIDE);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   prev;
   logic [MATCH_W-1:0] match_run;
   logic [MISS_W-1:0]  miss_run;
   logic               hit;

   // The prediction is derived only from registered state. The current sample
   // is therefore always judged against the previous sample, never itself.
   assign expected = prev + STEP;
   assign hit      = (data_in == expected);
   assign locked   = (state == LOCKED);

   // Main tracker: resync prev on every sample and step the lock state machine.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         prev      <= '0;
         match_run <= '0;
         miss_run  <= '0;
         err_cnt   <= '0;
         mismatch  <= 1'b0;
      end else if (clr) begin
         state     <= IDLE;
         match_run <= '0;
         miss_run  <= '0;
         err_cnt   <= '0;
         mismatch  <= 1'b0;
      end else begin
         mismatch <= 1'b0;
         if (en) begin
            prev <= data_in;
            case (state)
               IDLE: begin
                  state     <= ACQUIRE;
                  match_run <= '0;
               end
               ACQUIRE: begin
                  if (hit) begin
                     if (match_run == MATCH_LAST) begin
                        state     <= LOCKED;
                        match_run <= '0;
                        miss_run  <= '0;
                     end else begin
                        match_run <= match_run + MATCH_W'(1);
                     end
                  end else begin
                     match_run <= '0;
                  end
               end
               LOCKED: begin
                  if (hit) begin
                     miss_run <= '0;
                  end else begin
                     mismatch <= 1'b1;
                     if (err_cnt != '1) begin
                        err_cnt <= err_cnt + ERR_CW'(1);
                     end
                     if (miss_run == MISS_LAST) begin
                        state     <= ACQUIRE;
                        match_run <= '0;
                        miss_run  <= '0;
                     end else begin
                        miss_run <= miss_run + MISS_W'(1);
                     end
                  end
               end
               default: begin
                  state     <= IDLE;
                  match_run <= '0;
                  miss_run  <= '0;
               end
            endcase
         end
      end
   end

`ifdef EHGU_STRIDE_CHECKER_STICKY_EN
   // Latch any locked-state miss until reset or clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_sticky <= 1'b0;
      end else if (clr) begin
         err_sticky <= 1'b0;
      end else if (en && (state == LOCKED) && !hit) begin
         err_sticky <= 1'b1;
      end
   end
`else
   assign err_sticky = 1'b0;
`endif

endmodule
